// File: rtl/btn_cmd_scheduler_pkg.sv
// Shared definitions for the key command scheduler: FSM encodings and
// default parameter values.
package btn_cmd_scheduler_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_VALID = 2'b01,
    S_GAP   = 2'b10,
    S_BAD   = 2'b11
  } state_t;

  localparam int DEF_N_BTN   = 4;
  localparam int DEF_ID_W    = 2;
  localparam int DEF_GAP_CYC = 8;
  localparam int DEF_GAP_W   = 4;

endpackage

// File: rtl/btn_cmd_scheduler_rr_arbiter_n.sv
// Combinational round-robin picker: first set request searching upward
// from last_id+1, wrapping modulo N_BTN.
module rr_arbiter_n
  import btn_cmd_scheduler_pkg::*;
#(
  parameter int N_BTN = DEF_N_BTN,
  parameter int ID_W  = DEF_ID_W
) (
  input  logic [N_BTN-1:0] req,
  input  logic [ID_W-1:0]  last_id,
  output logic [ID_W-1:0]  gnt_id,
  output logic             gnt_any
);

  // cand[k] is the key at search distance k+1 from last_id
  logic [N_BTN-1:0][ID_W-1:0] cand;

  for (genvar k = 0; k < N_BTN; k++) begin : g_cand
    assign cand[k] = ID_W'((int'(last_id) + k + 1) % N_BTN);
  end

  // Scan farthest to nearest so the nearest requester is assigned last and wins
  always_comb begin
    gnt_id  = '0;
    gnt_any = 1'b0;
    for (int k = N_BTN - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        gnt_id  = cand[k];
        gnt_any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/btn_cmd_scheduler.sv
// Queues debounced key pulses as pending flags and issues them one at a
// time, round-robin, over valid/ready with a fixed idle gap after each accept.
module btn_cmd_scheduler
  import btn_cmd_scheduler_pkg::*;
#(
  parameter int N_BTN   = DEF_N_BTN,
  parameter int ID_W    = DEF_ID_W,
  parameter int GAP_CYC = DEF_GAP_CYC,
  parameter int GAP_W   = DEF_GAP_W
) (
  input  logic             CLK,
  input  logic             aclr_i,
  input  logic [N_BTN-1:0] sw_pulse,
  input  logic             cmd_ready,
  output logic             cmd_valid,
  output logic [ID_W-1:0]  cmd_id,
  output logic [N_BTN-1:0] pending,
  output logic             busy,
  output logic             dup_err
);

  state_t             state, state_nxt;
  logic [ID_W-1:0]    last_id, last_nxt, id_nxt, gnt_id;
  logic [GAP_W-1:0]   gap_cnt, gap_nxt;
  logic [N_BTN-1:0]   pend_nxt, acc_vec;
  logic               vld_nxt, dup_nxt, gnt_any;

  rr_arbiter_n #(.N_BTN(N_BTN), .ID_W(ID_W)) u_arb (
    .req     (pending),
    .last_id (last_id),
    .gnt_id  (gnt_id),
    .gnt_any (gnt_any)
  );

  assign busy = (state != S_IDLE);

  // Pending flags: pulses set, accepts clear; a pulse on an already pending,
  // non-accepted key is dropped and latches dup_err
  always_comb begin
    acc_vec = '0;
    if (cmd_valid && cmd_ready) acc_vec[cmd_id] = 1'b1;
    pend_nxt = (pending & ~acc_vec) | sw_pulse;
    dup_nxt  = dup_err | (|(sw_pulse & pending & ~acc_vec));
  end

  // Next-state and registered command outputs
  always_comb begin
    state_nxt = state;
    vld_nxt   = cmd_valid;
    id_nxt    = cmd_id;
    last_nxt  = last_id;
    gap_nxt   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (gnt_any) begin
          id_nxt    = gnt_id;
          vld_nxt   = 1'b1;
          state_nxt = S_VALID;
        end
      end
      S_VALID: begin
        if (cmd_ready) begin
          vld_nxt   = 1'b0;
          last_nxt  = cmd_id;
          gap_nxt   = GAP_W'(GAP_CYC - 1);
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) state_nxt = S_IDLE;
        else               gap_nxt   = gap_cnt - GAP_W'(1);
      end
      default: begin
        vld_nxt   = 1'b0;
        state_nxt = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset discards any in-flight command
  always_ff @(posedge CLK or posedge aclr_i) begin
    if (aclr_i) begin
      state     <= S_IDLE;
      cmd_valid <= 1'b0;
      cmd_id    <= '0;
      pending   <= '0;
      dup_err   <= 1'b0;
      last_id   <= ID_W'(N_BTN - 1);
      gap_cnt   <= '0;
    end else begin
      state     <= state_nxt;
      cmd_valid <= vld_nxt;
      cmd_id    <= id_nxt;
      pending   <= pend_nxt;
      dup_err   <= dup_nxt;
      last_id   <= last_nxt;
      gap_cnt   <= gap_nxt;
    end
  end

endmodule

// File: tb/tb_btn_cmd_scheduler.sv
// Bench for btn_cmd_scheduler: a cycle model built from pending flags,
// a round-robin search and an "earliest next grant" timestamp is compared
// against the DUT every cycle; directed tests add literal expectations.
module tb_btn_cmd_scheduler;

  localparam int N_BTN   = 4;
  localparam int ID_W    = 2;
  localparam int GAP_CYC = 8;
  localparam int GAP_W   = 4;

  logic             CLK = 1'b0;
  logic             aclr_i = 1'b1;
  logic [N_BTN-1:0] sw_pulse = '0;
  logic             cmd_ready = 1'b0;
  logic             cmd_valid;
  logic [ID_W-1:0]  cmd_id;
  logic [N_BTN-1:0] pending;
  logic             busy;
  logic             dup_err;

  btn_cmd_scheduler #(.N_BTN(N_BTN), .ID_W(ID_W), .GAP_CYC(GAP_CYC), .GAP_W(GAP_W)) dut (
    .CLK       (CLK),
    .aclr_i    (aclr_i),
    .sw_pulse  (sw_pulse),
    .cmd_ready (cmd_ready),
    .cmd_valid (cmd_valid),
    .cmd_id    (cmd_id),
    .pending   (pending),
    .busy      (busy),
    .dup_err   (dup_err)
  );

  always #5 CLK = ~CLK;

  int nvec = 0;
  int nerr = 0;
  int ncyc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input int exp);
    nvec++;
    if (act !== 32'(exp)) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [N_BTN-1:0] m_pend = '0;
  logic             m_valid = 1'b0;
  int               m_id = 0;
  int               m_last = N_BTN - 1;
  logic             m_dup = 1'b0;
  logic             m_busy = 1'b0;
  int               m_cyc = 0;
  int               m_ready_at = 0;  // first edge at which a new grant may happen
  logic             m_acc;
  logic [N_BTN-1:0] m_accv;
  int               m_w;

  function automatic int rr_pick(input logic [N_BTN-1:0] p, input int last);
    for (int k = 1; k <= N_BTN; k++)
      if (p[(last + k) % N_BTN]) return (last + k) % N_BTN;
    return -1;
  endfunction

  always @(posedge CLK or posedge aclr_i) begin
    if (aclr_i) begin
      m_pend = '0; m_valid = 1'b0; m_id = 0; m_last = N_BTN - 1;
      m_dup = 1'b0; m_busy = 1'b0; m_ready_at = 0;
    end else begin
      m_cyc++;
      m_acc  = m_valid && cmd_ready;
      m_accv = m_acc ? (N_BTN'(1) << m_id) : '0;
      m_w    = rr_pick(m_pend, m_last);
      if (m_acc) begin
        m_valid    = 1'b0;
        m_last     = m_id;
        m_ready_at = m_cyc + GAP_CYC + 1;
      end else if (!m_valid && m_w >= 0 && m_cyc >= m_ready_at) begin
        m_valid = 1'b1;
        m_id    = m_w;
      end
      m_dup  = m_dup | (|(sw_pulse & m_pend & ~m_accv));
      m_pend = (m_pend & ~m_accv) | sw_pulse;
      m_busy = m_valid || (m_cyc + 1 < m_ready_at);
    end
  end

  // ---------------- compare + grant log ----------------
  logic prev_v = 1'b0;
  int   q_id[$];
  int   q_cyc[$];

  always @(negedge CLK) begin
    ncyc++;
    chk("cmd_valid", cmd_valid, m_valid);
    if (m_valid) chk("cmd_id", cmd_id, m_id);
    chk("pending", pending, m_pend);
    chk("busy", busy, m_busy);
    chk("dup_err", dup_err, m_dup);
    if (cmd_valid && !prev_v) begin
      q_id.push_back(cmd_id);
      q_cyc.push_back(ncyc);
    end
    prev_v = cmd_valid;
  end

  // ---------------- stimulus helpers (call right after a negedge) ----------------
  task automatic pulse(input logic [N_BTN-1:0] p);
    sw_pulse = p;
    @(negedge CLK);
    sw_pulse = '0;
  endtask

  task automatic do_reset();
    #2 aclr_i = 1'b1;
    sw_pulse = '0;
    #1;
    chk("rst_valid", cmd_valid, 0);
    chk("rst_pend", pending, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dup", dup_err, 0);
    @(negedge CLK);
    aclr_i = 1'b0;
    q_id.delete();
    q_cyc.delete();
  endtask

  task automatic wait_valid();
    int b = 0;
    while (!cmd_valid && b < 100) begin @(negedge CLK); b++; end
    chk("wait_valid", cmd_valid, 1);
  endtask

  task automatic wait_grants(input int n);
    int b = 0;
    while (q_id.size() < n && b < 300) begin @(negedge CLK); b++; end
    chk("grant_count", q_id.size(), n);
  endtask

  task automatic chk_grant(input string nm, input int idx, input int exp);
    chk(nm, (idx < q_id.size()) ? q_id[idx] : -1, exp);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int cnt;
    // 1: reset and quiet idle
    repeat (2) @(negedge CLK);
    chk("reset_valid", cmd_valid, 0);
    chk("reset_id", cmd_id, 0);
    chk("reset_pend", pending, 0);
    chk("reset_busy", busy, 0);
    chk("reset_dup", dup_err, 0);
    aclr_i = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      chk("idle_valid", cmd_valid, 0);
    end

    // 2: single key, busy spans S_VALID plus GAP_CYC gap cycles
    cmd_ready = 1'b1;
    pulse(4'b0100);
    chk("t2_pend_set", pending, 4'b0100);
    chk("t2_not_yet", cmd_valid, 0);
    @(negedge CLK);
    chk("t2_valid", cmd_valid, 1);
    chk("t2_id", cmd_id, 2);
    cnt = 0;
    while (busy && cnt < 40) begin cnt++; @(negedge CLK); end
    chk("t2_busy_len", cnt, 1 + GAP_CYC);
    chk("t2_pend_clr", pending, 0);

    // 3: round-robin from a fresh last_id = N_BTN-1
    do_reset();
    cmd_ready = 1'b1;
    pulse(4'b1111);
    wait_grants(4);
    for (int i = 0; i < 4; i++) chk_grant("t3_order", i, i);
    for (int i = 0; i < 3 && i + 1 < q_cyc.size(); i++)
      chk("t3_spacing", q_cyc[i+1] - q_cyc[i], GAP_CYC + 2);
    pulse(4'b0011);
    wait_grants(6);
    chk_grant("t3_wrap0", 4, 0);
    chk_grant("t3_wrap1", 5, 1);

    // 4: backpressure holds the command, new pulse queues behind it
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0001);
    wait_valid();
    for (int i = 0; i < 10; i++) begin
      sw_pulse = (i == 3) ? 4'b1000 : 4'b0000;
      @(negedge CLK);
      chk("t4_hold_v", cmd_valid, 1);
      chk("t4_hold_id", cmd_id, 0);
    end
    sw_pulse = '0;
    chk("t4_pend", pending, 4'b1001);
    cmd_ready = 1'b1;
    wait_grants(2);
    chk_grant("t4_first", 0, 0);
    chk_grant("t4_second", 1, 3);

    // 5: pulse on accept cycle re-pends quietly; pulse while pending is a dup
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0010);
    wait_valid();
    cmd_ready = 1'b1;
    sw_pulse  = 4'b0010;
    @(negedge CLK);
    sw_pulse  = '0;
    cmd_ready = 1'b0;
    chk("t5_repend", pending, 4'b0010);
    chk("t5_no_dup", dup_err, 0);
    chk("t5_acc_v", cmd_valid, 0);
    pulse(4'b0010);
    chk("t5_dup", dup_err, 1);
    cmd_ready = 1'b1;
    wait_grants(2);
    chk_grant("t5_reissue", 1, 1);
    chk("t5_dup_sticky", dup_err, 1);

    // 6: reset in S_VALID and in S_GAP, then normal operation resumes
    do_reset();
    cmd_ready = 1'b0;
    pulse(4'b0001);
    wait_valid();
    do_reset();
    cmd_ready = 1'b1;
    pulse(4'b0100);
    wait_valid();
    repeat (3) @(negedge CLK);
    chk("t6_in_gap_busy", busy, 1);
    chk("t6_in_gap_v", cmd_valid, 0);
    do_reset();
    pulse(4'b0001);
    wait_grants(1);
    chk_grant("t6_post_rst", 0, 0);
    repeat (12) @(negedge CLK);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
